// File: rtl/cci_test_fiu_flow_throttle.sv
// Forced almost-full generator for the test AFU FIU flow-control layer.
// Combines per-channel occupancy limits (with slack and hysteresis) and a shared duty-cycle throttle.
module cci_test_fiu_flow_throttle #(
    parameter int unsigned MAX_ACTIVE_LINES = 512,
    parameter int unsigned CNT_WIDTH        = $clog2(MAX_ACTIVE_LINES) + 1,
    parameter int unsigned SLACK            = 8,
    parameter int unsigned HYST             = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    input  logic [CNT_WIDTH-1:0] cfg_c0_limit,
    input  logic [CNT_WIDTH-1:0] cfg_c1_limit,
    input  logic [7:0]           cfg_duty_on,
    input  logic [7:0]           cfg_duty_period,
    input  logic [CNT_WIDTH-1:0] c0ActiveLines,
    input  logic [CNT_WIDTH-1:0] c1ActiveLines,
    input  logic                 stats_clear,
    output logic                 c0ForceAlmFull,
    output logic                 c1ForceAlmFull,
    output logic [31:0]          c0_throttle_cycles,
    output logic [31:0]          c1_throttle_cycles
);

    localparam int unsigned    TW      = CNT_WIDTH + 1;
    localparam logic [TW-1:0]  SLACK_T = TW'(SLACK);
    localparam logic [TW-1:0]  HYST_T  = TW'(HYST);

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Thresholds use one extra bit so limit - SLACK can never wrap.
    function automatic state_e fsm_next(input state_e                 s,
                                        input logic [CNT_WIDTH-1:0] limit,
                                        input logic [CNT_WIDTH-1:0] active);
        logic [TW-1:0] lim_x;
        logic [TW-1:0] act_x;
        logic [TW-1:0] hi;
        logic [TW-1:0] lo;
        state_e        nxt;
        lim_x = {1'b0, limit};
        act_x = {1'b0, active};
        hi    = (lim_x > SLACK_T) ? lim_x - SLACK_T : TW'(1);
        lo    = (hi > HYST_T) ? hi - HYST_T : '0;
        nxt   = s;
        if (s == PASS) begin
            if (limit != '0 && act_x >= hi) nxt = HOLD;
        end else begin
            if (limit == '0 || act_x <= lo) nxt = PASS;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] stats_next(input logic        clear,
                                               input logic        inc,
                                               input logic [31:0] cnt);
        logic [31:0] nxt;
        nxt = cnt;
        if (clear)                   nxt = '0;
        else if (inc && cnt != '1)   nxt = cnt + 32'd1;
        return nxt;
    endfunction

    logic [CNT_WIDTH-1:0] c0_limit_q, c1_limit_q;
    logic [7:0]           duty_on_q, duty_period_q;
    logic [7:0]           duty_cnt_q, duty_cnt_d;
    logic [8:0]           duty_cnt_inc;
    logic                 duty_off_d;
    state_e               c0_state_q, c0_state_d;
    state_e               c1_state_q, c1_state_d;
    logic                 c0_force_q, c1_force_q;
    logic [31:0]          c0_stats_q, c0_stats_d;
    logic [31:0]          c1_stats_q, c1_stats_d;

    always_comb begin
        duty_cnt_inc = {1'b0, duty_cnt_q} + 9'd1;
        duty_cnt_d   = '0;
        if (!cfg_valid && duty_period_q != '0 && duty_cnt_inc < {1'b0, duty_period_q})
            duty_cnt_d = duty_cnt_inc[7:0];
        duty_off_d = (duty_period_q != '0) && (duty_cnt_d >= duty_on_q);

        c0_state_d = fsm_next(c0_state_q, c0_limit_q, c0ActiveLines);
        c1_state_d = fsm_next(c1_state_q, c1_limit_q, c1ActiveLines);

        c0_stats_d = stats_next(stats_clear, c0_force_q, c0_stats_q);
        c1_stats_d = stats_next(stats_clear, c1_force_q, c1_stats_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0_limit_q    <= '0;
            c1_limit_q    <= '0;
            duty_on_q     <= '0;
            duty_period_q <= '0;
            duty_cnt_q    <= '0;
            c0_state_q    <= PASS;
            c1_state_q    <= PASS;
            c0_force_q    <= 1'b0;
            c1_force_q    <= 1'b0;
            c0_stats_q    <= '0;
            c1_stats_q    <= '0;
        end else begin
            if (cfg_valid) begin
                c0_limit_q    <= cfg_c0_limit;
                c1_limit_q    <= cfg_c1_limit;
                duty_on_q     <= cfg_duty_on;
                duty_period_q <= cfg_duty_period;
            end
            duty_cnt_q <= duty_cnt_d;
            c0_state_q <= c0_state_d;
            c1_state_q <= c1_state_d;
            c0_force_q <= (c0_state_d == HOLD) | duty_off_d;
            c1_force_q <= (c1_state_d == HOLD) | duty_off_d;
            c0_stats_q <= c0_stats_d;
            c1_stats_q <= c1_stats_d;
        end
    end

    assign c0ForceAlmFull     = c0_force_q;
    assign c1ForceAlmFull     = c1_force_q;
    assign c0_throttle_cycles = c0_stats_q;
    assign c1_throttle_cycles = c1_stats_q;

endmodule
